// File: rtl/wb_reg_bank_pkg.sv
// Shared definitions for the write-back register bank: channel encodings,
// y2 encodings, privilege bit position and the interrupt-hold FSM states.
package wb_reg_bank_pkg;

    // y1 / read-select channel encoding (0, 10 and 15 select nothing)
    localparam logic [3:0] CH_NONE = 4'd0;
    localparam logic [3:0] CH_R1   = 4'd1;
    localparam logic [3:0] CH_R2   = 4'd2;
    localparam logic [3:0] CH_R3   = 4'd3;
    localparam logic [3:0] CH_R4   = 4'd4;
    localparam logic [3:0] CH_R5   = 4'd5;
    localparam logic [3:0] CH_R6   = 4'd6;
    localparam logic [3:0] CH_R7   = 4'd7;
    localparam logic [3:0] CH_DS   = 4'd8;
    localparam logic [3:0] CH_FLAG = 4'd9;
    localparam logic [3:0] CH_TPC  = 4'd11;
    localparam logic [3:0] CH_IPC  = 4'd12;
    localparam logic [3:0] CH_SP   = 4'd13;
    localparam logic [3:0] CH_TLB  = 4'd14;

    // y2 channel encoding (3 selects nothing)
    localparam logic [1:0] Y2_NONE = 2'd0;
    localparam logic [1:0] Y2_FLAG = 2'd1;
    localparam logic [1:0] Y2_SP   = 2'd2;

    // sys_info bit that marks user mode
    localparam int unsigned SYS_USER_BIT = 2;

    // Pending-interrupt FSM states
    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_t;

    // True for the general-purpose register channels r1..r7
    function automatic logic ch_is_gpr(input logic [3:0] ch);
        return (ch >= CH_R1) && (ch <= CH_R7);
    endfunction

endpackage

// File: rtl/wb_irq_hold.sv
// Single-entry pending-interrupt holder. Captures an external or
// tlb-violation event, holds it until acknowledged, drops events while
// pending, and reloads when an ack coincides with a new event.
module wb_irq_hold
    import wb_reg_bank_pkg::*;
#(
    parameter logic [7:0] TLB_VIOL_NUM = 8'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ext_irq,
    input  logic [7:0] ext_irq_num,
    input  logic       tlb_viol,
    input  logic       irq_ack,
    output logic       irq_req,
    output logic [7:0] irq_num
);

    irq_state_t state_q, state_d;
    logic [7:0] num_q, num_d;
    logic       evt;
    logic [7:0] evt_num;

    // External interrupt takes priority over a simultaneous tlb violation
    always_comb begin
        evt     = ext_irq | tlb_viol;
        evt_num = ext_irq ? ext_irq_num : TLB_VIOL_NUM;
    end

    // Next-state and capture logic
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (evt) begin
                    state_d = IRQ_PEND;
                    num_d   = evt_num;
                end
            end
            IRQ_PEND: begin
                if (irq_ack) begin
                    if (evt) begin
                        num_d = evt_num;
                    end else begin
                        state_d = IRQ_IDLE;
                    end
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

    // State and number registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IRQ_IDLE;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
        end
    end

    // Outputs are direct register views
    always_comb begin
        irq_req = (state_q == IRQ_PEND);
        irq_num = num_q;
    end

endmodule

// File: rtl/wb_reg_bank.sv
// Write-back register bank: owns r1-r7, ds, flag, tpc, ipc, sp and tlb,
// applies y1/y2 write-back with y2 priority on shared targets, blocks
// user-mode tlb writes (raising an interrupt) and serves two registered
// read ports.
// Optional macro WB_REG_BANK_BYPASS_EN: read ports return same-cycle write
// data; otherwise they return the pre-write value.
module wb_reg_bank
    import wb_reg_bank_pkg::*;
#(
    parameter int unsigned       DATA_W       = 32,
    parameter logic [DATA_W-1:0] SP_RST       = '0,
    parameter logic [DATA_W-1:0] FLAG_RST     = '0,
    parameter logic [7:0]        TLB_VIOL_NUM = 8'd8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        y1_channel,
    input  logic [DATA_W-1:0] y1_data,
    input  logic [1:0]        y2_channel,
    input  logic [DATA_W-1:0] y2_data,
    input  logic [31:0]       sys_info,
    input  logic              ext_irq,
    input  logic [7:0]        ext_irq_num,
    input  logic [3:0]        rd_a_sel,
    input  logic [3:0]        rd_b_sel,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic [DATA_W-1:0] flag_q,
    output logic [DATA_W-1:0] sp_q,
    output logic [DATA_W-1:0] tlb_q,
    output logic              irq_req,
    output logic [7:0]        irq_num,
    input  logic              irq_ack
);

    logic [DATA_W-1:0] gpr     [1:7];
    logic [DATA_W-1:0] gpr_nxt [1:7];
    logic [DATA_W-1:0] ds_q, tpc_q, ipc_q;
    logic [DATA_W-1:0] ds_nxt, flag_nxt, tpc_nxt, ipc_nxt, sp_nxt, tlb_nxt;
    logic [DATA_W-1:0] rd_a_src, rd_b_src;
    logic              user_mode;
    logic              tlb_viol;
    logic              unused_sys_bits;

    assign unused_sys_bits = ^{sys_info[31:SYS_USER_BIT+1], sys_info[SYS_USER_BIT-1:0]};

    // Select one register out of a full register-set snapshot
    function automatic logic [DATA_W-1:0] pick(
        input logic [3:0]        sel,
        input logic [DATA_W-1:0] g [1:7],
        input logic [DATA_W-1:0] ds,
        input logic [DATA_W-1:0] fl,
        input logic [DATA_W-1:0] tp,
        input logic [DATA_W-1:0] ip,
        input logic [DATA_W-1:0] s,
        input logic [DATA_W-1:0] t
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (ch_is_gpr(sel)) begin
            v = g[sel[2:0]];
        end else begin
            case (sel)
                CH_DS:   v = ds;
                CH_FLAG: v = fl;
                CH_TPC:  v = tp;
                CH_IPC:  v = ip;
                CH_SP:   v = s;
                CH_TLB:  v = t;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Privilege check on tlb writes
    always_comb begin
        user_mode = sys_info[SYS_USER_BIT];
        tlb_viol  = (y1_channel == CH_TLB) && user_mode;
    end

    // Next register contents: y1 first, then y2 overrides shared targets
    always_comb begin
        gpr_nxt  = gpr;
        ds_nxt   = ds_q;
        flag_nxt = flag_q;
        tpc_nxt  = tpc_q;
        ipc_nxt  = ipc_q;
        sp_nxt   = sp_q;
        tlb_nxt  = tlb_q;
        for (int unsigned i = 1; i <= 7; i++) begin
            if (y1_channel == 4'(i)) begin
                gpr_nxt[i] = y1_data;
            end
        end
        case (y1_channel)
            CH_DS:   ds_nxt   = y1_data;
            CH_FLAG: flag_nxt = y1_data;
            CH_TPC:  tpc_nxt  = y1_data;
            CH_IPC:  ipc_nxt  = y1_data;
            CH_SP:   sp_nxt   = y1_data;
            CH_TLB:  if (!user_mode) tlb_nxt = y1_data;
            default: ;
        endcase
        case (y2_channel)
            Y2_FLAG: flag_nxt = y2_data;
            Y2_SP:   sp_nxt   = y2_data;
            default: ;
        endcase
    end

    // Architectural register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i <= 7; i++) begin
                gpr[i] <= '0;
            end
            ds_q   <= '0;
            flag_q <= FLAG_RST;
            tpc_q  <= '0;
            ipc_q  <= '0;
            sp_q   <= SP_RST;
            tlb_q  <= '0;
        end else begin
            gpr    <= gpr_nxt;
            ds_q   <= ds_nxt;
            flag_q <= flag_nxt;
            tpc_q  <= tpc_nxt;
            ipc_q  <= ipc_nxt;
            sp_q   <= sp_nxt;
            tlb_q  <= tlb_nxt;
        end
    end

    // Read source: the post-write snapshot already folds in y2 priority
    // and the blocked tlb write, so bypass needs no separate match logic
    always_comb begin
`ifdef WB_REG_BANK_BYPASS_EN
        rd_a_src = pick(rd_a_sel, gpr_nxt, ds_nxt, flag_nxt, tpc_nxt, ipc_nxt, sp_nxt, tlb_nxt);
        rd_b_src = pick(rd_b_sel, gpr_nxt, ds_nxt, flag_nxt, tpc_nxt, ipc_nxt, sp_nxt, tlb_nxt);
`else
        rd_a_src = pick(rd_a_sel, gpr, ds_q, flag_q, tpc_q, ipc_q, sp_q, tlb_q);
        rd_b_src = pick(rd_b_sel, gpr, ds_q, flag_q, tpc_q, ipc_q, sp_q, tlb_q);
`endif
    end

    // Registered operand read ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_data <= '0;
            rd_b_data <= '0;
        end else begin
            rd_a_data <= rd_a_src;
            rd_b_data <= rd_b_src;
        end
    end

    wb_irq_hold #(
        .TLB_VIOL_NUM (TLB_VIOL_NUM)
    ) u_irq_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .ext_irq     (ext_irq),
        .ext_irq_num (ext_irq_num),
        .tlb_viol    (tlb_viol),
        .irq_ack     (irq_ack),
        .irq_req     (irq_req),
        .irq_num     (irq_num)
    );

endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed self-checking bench for wb_reg_bank.
module tb_wb_reg_bank;

    localparam logic [31:0] SP_R  = 32'h0000_F000;
    localparam logic [31:0] FL_R  = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  y1_channel;
    logic [31:0] y1_data;
    logic [1:0]  y2_channel;
    logic [31:0] y2_data;
    logic [31:0] sys_info;
    logic        ext_irq;
    logic [7:0]  ext_irq_num;
    logic [3:0]  rd_a_sel, rd_b_sel;
    logic [31:0] rd_a_data, rd_b_data;
    logic [31:0] flag_q, sp_q, tlb_q;
    logic        irq_req;
    logic [7:0]  irq_num;
    logic        irq_ack;

    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;
    int unsigned total    = 0;

    always #5 clk = ~clk;

    wb_reg_bank #(
        .DATA_W       (32),
        .SP_RST       (SP_R),
        .FLAG_RST     (FL_R),
        .TLB_VIOL_NUM (8'd8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .y1_channel  (y1_channel),
        .y1_data     (y1_data),
        .y2_channel  (y2_channel),
        .y2_data     (y2_data),
        .sys_info    (sys_info),
        .ext_irq     (ext_irq),
        .ext_irq_num (ext_irq_num),
        .rd_a_sel    (rd_a_sel),
        .rd_b_sel    (rd_b_sel),
        .rd_a_data   (rd_a_data),
        .rd_b_data   (rd_b_data),
        .flag_q      (flag_q),
        .sp_q        (sp_q),
        .tlb_q       (tlb_q),
        .irq_req     (irq_req),
        .irq_num     (irq_num),
        .irq_ack     (irq_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reset_val(input int unsigned sel);
        if (sel == 9)  return FL_R;
        if (sel == 13) return SP_R;
        return 32'h0;
    endfunction

    initial begin
        rst_n = 1'b0;
        y1_channel = 4'd0; y1_data = '0;
        y2_channel = 2'd0; y2_data = '0;
        sys_info = '0; ext_irq = 1'b0; ext_irq_num = '0;
        rd_a_sel = 4'd0; rd_b_sel = 4'd0; irq_ack = 1'b0;

        // Reset state
        #12;
        check("rst irq_req", 32'(irq_req), 32'h0);
        check("rst irq_num", 32'(irq_num), 32'h0);
        check("rst rd_a", rd_a_data, 32'h0);
        check("rst rd_b", rd_b_data, 32'h0);
        check("rst sp", sp_q, SP_R);
        check("rst flag", flag_q, FL_R);
        check("rst tlb", tlb_q, 32'h0);
        #5;
        rst_n = 1'b1;

        // Read every select on both ports after reset
        for (int unsigned i = 0; i < 16; i++) begin
            rd_a_sel = 4'(i);
            rd_b_sel = 4'(15 - i);
            tick();
            check($sformatf("rst read a sel%0d", i), rd_a_data, reset_val(i));
            check($sformatf("rst read b sel%0d", 15 - i), rd_b_data, reset_val(15 - i));
        end
        check("rst irq_req idle", 32'(irq_req), 32'h0);

        // y1 write to r3, read in same cycle then next cycle
        y1_channel = 4'd3; y1_data = 32'hDEAD_BEEF; rd_a_sel = 4'd3;
        tick();
`ifdef WB_REG_BANK_BYPASS_EN
        check("r3 same-cycle read", rd_a_data, 32'hDEAD_BEEF);
`else
        check("r3 same-cycle read", rd_a_data, 32'h0);
`endif
        y1_channel = 4'd0;
        tick();
        check("r3 read", rd_a_data, 32'hDEAD_BEEF);

        // sp collision: y2 wins
        y1_channel = 4'd13; y1_data = 32'h100; y2_channel = 2'd2; y2_data = 32'h200;
        tick();
        check("sp collision", sp_q, 32'h200);
        // different targets commit together
        y1_channel = 4'd9; y1_data = 32'hAA; y2_channel = 2'd2; y2_data = 32'h300;
        tick();
        check("dual flag", flag_q, 32'hAA);
        check("dual sp", sp_q, 32'h300);
        // flag collision: y2 wins
        y1_channel = 4'd9; y1_data = 32'h11; y2_channel = 2'd1; y2_data = 32'h22;
        tick();
        check("flag collision", flag_q, 32'h22);
        // channels 10 and 15 write nothing; y2=3 writes nothing
        y1_channel = 4'd10; y1_data = 32'h9999; y2_channel = 2'd3; y2_data = 32'h8888;
        tick();
        check("nop y2 flag", flag_q, 32'h22);
        check("nop y2 sp", sp_q, 32'h300);
        // sp collision with read of sp in same cycle
        y1_channel = 4'd13; y1_data = 32'hA; y2_channel = 2'd2; y2_data = 32'hB; rd_a_sel = 4'd13;
        tick();
`ifdef WB_REG_BANK_BYPASS_EN
        check("sp bypass prio", rd_a_data, 32'hB);
`else
        check("sp bypass prio", rd_a_data, 32'h300);
`endif
        check("sp after prio", sp_q, 32'hB);
        y1_channel = 4'd0; y2_channel = 2'd0;

        // Kernel tlb write
        sys_info = 32'h0; y1_channel = 4'd14; y1_data = 32'h1234;
        tick();
        check("kernel tlb", tlb_q, 32'h1234);
        check("kernel tlb no irq", 32'(irq_req), 32'h0);
        // User tlb write blocked, raises irq 8, not bypassed
        sys_info = 32'h4; y1_channel = 4'd14; y1_data = 32'h55; rd_a_sel = 4'd14;
        tick();
        check("user tlb blocked", tlb_q, 32'h1234);
        check("user tlb read", rd_a_data, 32'h1234);
        check("viol irq_req", 32'(irq_req), 32'h1);
        check("viol irq_num", 32'(irq_num), 32'h8);
        y1_channel = 4'd0; sys_info = 32'h0; irq_ack = 1'b1;
        tick();
        check("ack clears", 32'(irq_req), 32'h0);
        tick();
        check("ack idle ignored", 32'(irq_req), 32'h0);
        irq_ack = 1'b0;

        // External wins over simultaneous violation
        ext_irq = 1'b1; ext_irq_num = 8'h21; sys_info = 32'h4; y1_channel = 4'd14; y1_data = 32'h66;
        tick();
        check("ext prio req", 32'(irq_req), 32'h1);
        check("ext prio num", 32'(irq_num), 32'h21);
        check("ext prio tlb", tlb_q, 32'h1234);
        // Event while pending dropped
        ext_irq_num = 8'h30; y1_channel = 4'd0; sys_info = 32'h0;
        tick();
        check("pend hold num", 32'(irq_num), 32'h21);
        // Ack with new event reloads
        ext_irq_num = 8'h44; irq_ack = 1'b1;
        tick();
        check("ack+evt req", 32'(irq_req), 32'h1);
        check("ack+evt num", 32'(irq_num), 32'h44);
        ext_irq = 1'b0;
        tick();
        check("final ack", 32'(irq_req), 32'h0);
        irq_ack = 1'b0;

        // r5 hazard read
        y1_channel = 4'd5; y1_data = 32'h99;
        tick();
        y1_channel = 4'd5; y1_data = 32'h7; rd_b_sel = 4'd5;
        tick();
`ifdef WB_REG_BANK_BYPASS_EN
        check("r5 hazard", rd_b_data, 32'h7);
`else
        check("r5 hazard", rd_b_data, 32'h99);
`endif
        y1_channel = 4'd0;
        tick();
        check("r5 read", rd_b_data, 32'h7);

        // Asynchronous reset while pending
        ext_irq = 1'b1; ext_irq_num = 8'h5A;
        tick();
        ext_irq = 1'b0;
        check("pend before rst", 32'(irq_req), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst irq_req", 32'(irq_req), 32'h0);
        check("async rst irq_num", 32'(irq_num), 32'h0);
        check("async rst sp", sp_q, SP_R);
        check("async rst flag", flag_q, FL_R);
        check("async rst tlb", tlb_q, 32'h0);
        check("async rst rd_b", rd_b_data, 32'h0);
        #2;
        rst_n = 1'b1;
        rd_a_sel = 4'd3;
        tick();
        check("r3 after rst", rd_a_data, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/wb_reg_bank.md
Name: wb_reg_bank

Overview:
- Receiving end of the write-back channel: latches y1/y2 write-back traffic into the architectural register set (r1–r7, ds, flag, tpc, ipc, sp, tlb).
- Serves two registered operand read ports to decode, using the same 4-bit channel encoding as the write-back side.
- Enforces the privileged tlb-write rule and holds a single pending interrupt request until the core acknowledges it.
- Sits between write-back and operand fetch; owns all architectural register state.

Parameters:
- DATA_W, 32, register/data width.
- SP_RST, 32'h0000_0000, sp reset value.
- FLAG_RST, 32'h0000_0000, flag reset value.
- TLB_VIOL_NUM, 8, interrupt number raised on a user-mode tlb write.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- y1_channel  in  4  y1 target: 1–7 r1–r7, 8 ds, 9 flag, 11 tpc, 12 ipc, 13 sp, 14 tlb; 0/10/15 no write.
- y1_data  in  DATA_W  y1 write data.
- y2_channel  in  2  0 none, 1 flag, 2 sp, 3 none.
- y2_data  in  DATA_W  y2 write data.
- sys_info  in  32  bit2 = 1 means user mode.
- ext_irq  in  1  external interrupt event (one-cycle pulse).
- ext_irq_num  in  8  external interrupt number.
- rd_a_sel, rd_b_sel  in  4  read selects, same encoding as y1_channel.
- rd_a_data, rd_b_data  out  DATA_W  registered read data.
- flag_q, sp_q, tlb_q  out  DATA_W  direct register views.
- irq_req  out  1  interrupt pending.
- irq_num  out  8  pending interrupt number.
- irq_ack  in  1  core accepts the pending interrupt.

Behaviour:
- Reset (async, rst_n low):
  - All registers clear to 0, except sp = SP_RST and flag = FLAG_RST.
  - rd_a_data = rd_b_data = 0.
  - irq_req = 0, irq_num = 0.
- Writes on rising clk:
  - y1 writes the selected register; channels 0, 10 and 15 write nothing.
  - y2 writes flag (1) or sp (2).
  - Collision with the same target (y1=9 & y2=1, or y1=13 & y2=2): y2 wins.
  - Different targets: both writes commit in the same cycle.
- tlb protection:
  - y1_channel=14 with sys_info[2]=0 writes tlb.
  - y1_channel=14 with sys_info[2]=1 leaves tlb unchanged and raises a tlb-violation event with number TLB_VIOL_NUM.
- Reads:
  - One-cycle latency: rd_x_data at edge N+1 = contents of rd_x_sel at edge N.
  - Without bypass, the value returned is the pre-write value.
  - Selects 0, 10 and 15 return 0.
- Interrupt state machine, two states:
  - IDLE -> PEND on ext_irq or a tlb-violation event. irq_num captures ext_irq_num if ext_irq is set, otherwise TLB_VIOL_NUM; external wins on simultaneous events.
  - PEND: irq_req = 1 and irq_num is held. Further events are dropped.
  - PEND -> IDLE on irq_ack.
  - irq_ack together with a new event in the same cycle: stay in PEND and load the new number.
  - irq_ack while in IDLE: ignored.
- Reset mid-PEND clears the pending request immediately (asynchronous).
- No arithmetic is performed; data passes through at full DATA_W width.

Optional Feature:
- Macro WB_REG_BANK_BYPASS_EN.
- Defined: a read whose select matches a register being written in the same cycle returns the new value, after y2-over-y1 priority. A blocked user-mode tlb write is not bypassed.
- Undefined: reads return the pre-write value, and decode must stall one cycle on a hazard.

Decomposition:
- Shared package holds:
  - Channel encoding constants CH_R1..CH_R7, CH_DS, CH_FLAG, CH_TPC, CH_IPC, CH_SP, CH_TLB.
  - y2 encodings Y2_NONE, Y2_FLAG, Y2_SP.
  - SYS_USER_BIT = 2.
  - Interrupt FSM state typedef.
- One natural sub-module, wb_irq_hold: the pending-interrupt FSM with capture, ack and priority logic.

Test Plan:
- Reset, then read all selects -> sp reads SP_RST, flag reads FLAG_RST, every other select reads 0; irq_req = 0.
- y1_channel=3, y1_data=32'hDEAD_BEEF, then rd_a_sel=3 -> rd_a_data = 32'hDEAD_BEEF one cycle later.
- y1_channel=13 with data 32'h100 and y2_channel=2 with data 32'h200 in the same cycle -> sp_q = 32'h200.
- sys_info[2]=1, y1_channel=14, data 32'h55 -> tlb_q unchanged; irq_req = 1 and irq_num = 8 next cycle. irq_ack -> irq_req = 0.
- ext_irq with num 8'h21 simultaneous with a user-mode tlb write -> irq_num = 8'h21. A second ext_irq with num 8'h30 while pending -> irq_num stays 8'h21.
- With WB_REG_BANK_BYPASS_EN: write r5 = 32'h7 with rd_b_sel=5 in the same cycle -> rd_b_data = 32'h7 next cycle. Without the macro: the old r5 value.
